// File: rtl/hbridge_deadtime.sv
// Full-bridge gate driver with programmable dead time on every complementary
// switch and on every direction reversal. All outputs are registered.
module hbridge_deadtime #(
    parameter int DEAD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  dir,
    input  logic                  pwm_in,
    input  logic [DEAD_WIDTH-1:0] dead_cycles,
    output logic                  a_hi,
    output logic                  a_lo,
    output logic                  b_hi,
    output logic                  b_lo,
    output logic                  in_dead
);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        DEAD_LH,
        HIGH,
        DEAD_HL,
        DIRCHG
    } state_t;

    state_t                state_q, state_d;
    logic [DEAD_WIDTH-1:0] cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic [DEAD_WIDTH-1:0] load_val;

    logic a_hi_d, a_lo_d, b_hi_d, b_lo_d, in_dead_d;
    logic act_hi, act_lo, inact_lo;

    // Counter is loaded with D-1 where D = max(dead_cycles, 1).
    assign load_val = (dead_cycles == '0) ? '0 : dead_cycles - 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (!enable) begin
            state_d = IDLE;
        end else if ((dir != dir_q) &&
                     (state_q inside {LOW, HIGH, DEAD_LH, DEAD_HL})) begin
            state_d = DIRCHG;
            cnt_d   = load_val;
        end else begin
            case (state_q)
                IDLE: begin
                    dir_d   = dir;
                    state_d = LOW;
                end
                LOW: begin
                    if (pwm_in) begin
                        state_d = DEAD_LH;
                        cnt_d   = load_val;
                    end
                end
                DEAD_LH: begin
                    if (!pwm_in)           state_d = LOW;
                    else if (cnt_q == '0)  state_d = HIGH;
                    else                   cnt_d   = cnt_q - 1'b1;
                end
                HIGH: begin
                    if (!pwm_in) begin
                        state_d = DEAD_HL;
                        cnt_d   = load_val;
                    end
                end
                DEAD_HL: begin
                    if (pwm_in)            state_d = HIGH;
                    else if (cnt_q == '0)  state_d = LOW;
                    else                   cnt_d   = cnt_q - 1'b1;
                end
                DIRCHG: begin
                    if (cnt_q == '0) begin
                        dir_d   = dir;
                        state_d = LOW;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Gate decode from the next state so the flops always mirror the state.
    always_comb begin
        act_hi   = 1'b0;
        act_lo   = 1'b0;
        inact_lo = 1'b0;
        case (state_d)
            LOW: begin
                act_lo   = 1'b1;
                inact_lo = 1'b1;
            end
            HIGH: begin
                act_hi   = 1'b1;
                inact_lo = 1'b1;
            end
            DEAD_LH, DEAD_HL: inact_lo = 1'b1;
            default: ;
        endcase
        a_hi_d    = dir_d & act_hi;
        a_lo_d    = dir_d ? act_lo : inact_lo;
        b_hi_d    = ~dir_d & act_hi;
        b_lo_d    = dir_d ? inact_lo : act_lo;
        in_dead_d = (state_d inside {DEAD_LH, DEAD_HL, DIRCHG});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
            a_hi    <= 1'b0;
            a_lo    <= 1'b0;
            b_hi    <= 1'b0;
            b_lo    <= 1'b0;
            in_dead <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            a_hi    <= a_hi_d;
            a_lo    <= a_lo_d;
            b_hi    <= b_hi_d;
            b_lo    <= b_lo_d;
            in_dead <= in_dead_d;
        end
    end

endmodule

// File: tb/tb_hbridge_deadtime.sv
// Scoreboard bench for hbridge_deadtime: a behavioural bridge model predicts
// each cycle's gate pattern, a monitor compares and watches safety invariants.
module tb_hbridge_deadtime;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       dir = 1'b1;
    logic       pwm_in = 1'b0;
    logic [7:0] dead_cycles = '0;
    logic       a_hi, a_lo, b_hi, b_lo, in_dead;

    hbridge_deadtime #(.DEAD_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .dir(dir), .pwm_in(pwm_in),
        .dead_cycles(dead_cycles), .a_hi(a_hi), .a_lo(a_lo), .b_hi(b_hi),
        .b_lo(b_lo), .in_dead(in_dead)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [4:0]  exp_q[$];

    // Model: powered flag, direction, settled level, and a pending transition
    // (kind 1 = toward m_tgt, kind 2 = direction change) with cycles remaining.
    bit m_on = 0, m_dir = 1, m_level = 0, m_tgt = 0;
    int m_kind = 0, m_left = 0;

    int  dead_run = 0, last_dead_run = 0;
    int  alo_zero_run = 0, blo_zero_run = 0;
    bit  prev_ahi = 0, prev_bhi = 0, hi_seen = 0;

    task automatic model_reset();
        m_on = 0; m_dir = 1; m_level = 0; m_kind = 0; m_left = 0;
    endtask

    task automatic model_edge(input bit en, input bit d, input bit p, input int dc);
        int dd;
        dd = (dc == 0) ? 1 : dc;
        if (!en) begin
            m_on = 0; m_kind = 0;
        end else if (!m_on) begin
            m_on = 1; m_dir = d; m_level = 0; m_kind = 0;
        end else if (m_kind != 2 && d != m_dir) begin
            m_kind = 2; m_left = dd;
        end else if (m_kind == 2) begin
            m_left--;
            if (m_left == 0) begin m_dir = d; m_level = 0; m_kind = 0; end
        end else if (m_kind == 0) begin
            if (p != m_level) begin m_kind = 1; m_tgt = p; m_left = dd; end
        end else begin
            if (p != m_tgt) m_kind = 0;
            else begin
                m_left--;
                if (m_left == 0) begin m_level = m_tgt; m_kind = 0; end
            end
        end
    endtask

    function automatic logic [4:0] model_out();
        bit ah, al, bh, bl, dd, act_hi, act_lo;
        if (!m_on || m_kind == 2) begin
            ah = 0; al = 0; bh = 0; bl = 0;
            dd = m_on && (m_kind == 2);
        end else begin
            act_hi = (m_kind == 0) && m_level;
            act_lo = (m_kind == 0) && !m_level;
            dd = (m_kind != 0);
            if (m_dir) begin ah = act_hi; al = act_lo; bh = 0; bl = 1; end
            else begin ah = 0; al = 1; bh = act_hi; bl = act_lo; end
        end
        return {ah, al, bh, bl, dd};
    endfunction

    task automatic step(input bit en, input bit d, input bit p, input int dc);
        @(negedge clk);
        rst = 1'b1; enable = en; dir = d; pwm_in = p; dead_cycles = dc[7:0];
        model_edge(en, d, p, dc);
        exp_q.push_back(model_out());
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare against the scoreboard and watch invariants each cycle.
    initial begin
        logic [4:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            a = {a_hi, a_lo, b_hi, b_lo, in_dead};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard @%0t: got {ahi,alo,bhi,blo,dead}=%b expected %b",
                             $time, a, e);
                end
            end
            checks++;
            if ((a_hi && a_lo) || (b_hi && b_lo) || (a_hi && b_hi)) begin
                errors++;
                $display("FAIL shoot_through @%0t: gates %b", $time, a[4:1]);
            end
            if (a_hi && !prev_ahi) check("a_hi_after_lo_off", alo_zero_run >= 1, 1);
            if (b_hi && !prev_bhi) check("b_hi_after_lo_off", blo_zero_run >= 1, 1);
            if (a_hi || b_hi) hi_seen = 1;
            alo_zero_run = a_lo ? 0 : alo_zero_run + 1;
            blo_zero_run = b_lo ? 0 : blo_zero_run + 1;
            prev_ahi = a_hi; prev_bhi = b_hi;
            if (in_dead) dead_run++;
            else begin
                if (dead_run != 0) last_dead_run = dead_run;
                dead_run = 0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit en, d, p;
        int dc;
        // Reset held with random inputs: all gates off.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            enable = 1'($urandom); dir = 1'($urandom); pwm_in = 1'($urandom);
            dead_cycles = 8'($urandom);
            @(posedge clk); #1;
            check("reset_gates", {a_hi, a_lo, b_hi, b_lo, in_dead}, 0);
        end
        model_reset();
        // Release into forward LOW.
        step(1, 1, 0, 4);
        @(posedge clk); #2;
        check("release_a_lo", a_lo, 1);
        check("release_b_lo", b_lo, 1);
        for (int i = 0; i < 2; i++) step(1, 1, 0, 4);
        // Forward dead time of 4 each way.
        for (int i = 0; i < 8; i++) step(1, 1, 1, 4);
        check("fwd_lh_dead_len", last_dead_run, 4);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 4);
        check("fwd_hl_dead_len", last_dead_run, 4);
        // dead_cycles = 0 behaves as one dead cycle.
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        check("zero_lh_dead_len", last_dead_run, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        check("zero_hl_dead_len", last_dead_run, 1);
        // Short high pulse is swallowed.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 5);
        @(posedge clk); #2; hi_seen = 0;
        for (int i = 0; i < 3; i++) step(1, 1, 1, 5);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 5);
        @(posedge clk); #2;
        check("short_pulse_no_hi", hi_seen, 0);
        // Reversal from forward HIGH.
        for (int i = 0; i < 6; i++) step(1, 1, 1, 3);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 3);
        check("dirchg_len", last_dead_run, 3);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 3);
        @(posedge clk); #2;
        check("rev_b_hi", b_hi, 1);
        check("rev_a_lo", a_lo, 1);
        // Async reset in the middle of a dead interval.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 3);
        for (int i = 0; i < 2; i++) step(1, 0, 1, 6);
        @(posedge clk); #1;
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("async_reset_gates", {a_hi, a_lo, b_hi, b_lo, in_dead}, 0);
        model_reset();
        // Random soak.
        en = 1; d = 1; p = 0; dc = 2;
        for (int i = 0; i < 10000; i++) begin
            en = ($urandom_range(199) != 0);
            if ($urandom_range(49) == 0) d = ~d;
            if ($urandom_range(3) == 0) p = ~p;
            if ($urandom_range(99) == 0)
                dc = ($urandom_range(19) == 0) ? 255 : $urandom_range(0, 7);
            step(en, d, p, dc);
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
